// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one registered 32x32 multiplier (low-32 result) between NUM_REQ
// requesters, with an ID tag pipe matching the multiplier latency and a one-entry result buffer each.
module mult_share_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int MUL_LAT = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [32*NUM_REQ-1:0] req_op_a,
   input  logic [32*NUM_REQ-1:0] req_op_b,
   output logic [NUM_REQ-1:0]    rsp_valid,
   input  logic [NUM_REQ-1:0]    rsp_ready,
   output logic [32*NUM_REQ-1:0] rsp_result,
   output logic                  mul_en,
   output logic [31:0]           mul_op_a,
   output logic [31:0]           mul_op_b,
   input  logic [31:0]           mul_result,
   output logic                  busy
);

   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0] pending;
   logic [NUM_REQ-1:0] eligible;
   logic [ID_W-1:0]    rr_ptr;
   logic [ID_W-1:0]    gnt_idx;
   logic               gnt_any;
   logic [MUL_LAT-1:0] tag_vld;
   logic [ID_W-1:0]    tag_id [MUL_LAT];

   // A result still buffered (or in flight) blocks a new grant to the same requester.
   assign eligible = req_valid & ~pending;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         int cand;
         cand = int'(rr_ptr) + off;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_any && rst_n && (i == cand) && eligible[i]) begin
               gnt_any = 1'b1;
               gnt_idx = ID_W'(i);
            end
         end
      end
   end

   always_comb begin
      req_ready = '0;
      mul_op_a  = '0;
      mul_op_b  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_any && (gnt_idx == ID_W'(i))) begin
            req_ready[i] = 1'b1;
            mul_op_a     = req_op_a[32*i +: 32];
            mul_op_b     = req_op_b[32*i +: 32];
         end
      end
   end

   assign mul_en = gnt_any;
   assign busy   = |pending;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr     <= ID_W'(NUM_REQ - 1);
         pending    <= '0;
         rsp_valid  <= '0;
         rsp_result <= '0;
         tag_vld    <= '0;
      end else begin
         // NOTE: all state updates are non-blocking so every bit sees pre-edge values.
         if (gnt_any) rr_ptr <= gnt_idx;
         tag_vld[0] <= gnt_any;
         for (int s = 1; s < MUL_LAT; s++) tag_vld[s] <= tag_vld[s-1];
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i])
               pending[i] <= 1'b1;
            else if (rsp_valid[i] && rsp_ready[i])
               pending[i] <= 1'b0;
            if (tag_vld[MUL_LAT-1] && (tag_id[MUL_LAT-1] == ID_W'(i))) begin
               rsp_valid[i]           <= 1'b1;
               rsp_result[32*i +: 32] <= mul_result;
            end else if (rsp_valid[i] && rsp_ready[i]) begin
               rsp_valid[i] <= 1'b0;
            end
         end
      end
   end

   // NOTE: tag ids mean nothing unless the matching tag_vld bit is set, so they carry no reset.
   always_ff @(posedge clk) begin
      tag_id[0] <= gnt_idx;
      for (int s = 1; s < MUL_LAT; s++) tag_id[s] <= tag_id[s-1];
   end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter: directed operand pairs with hand-computed products,
// a requester driver, a registered multiplier model and a monitor that checks every cycle.
module tb_mult_share_arbiter;
   localparam int NUM_REQ = 4;
   localparam int MUL_LAT = 1;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [32*NUM_REQ-1:0] req_op_a;
   logic [32*NUM_REQ-1:0] req_op_b;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic [NUM_REQ-1:0]    rsp_ready;
   logic [32*NUM_REQ-1:0] rsp_result;
   logic                  mul_en;
   logic [31:0]           mul_op_a;
   logic [31:0]           mul_op_b;
   logic [31:0]           mul_result;
   logic                  busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [31:0] op_a_q [NUM_REQ][$];
   logic [31:0] op_b_q [NUM_REQ][$];
   logic [31:0] exp_q  [NUM_REQ][$];
   int          grant_log [$];
   int          grant_cyc [$];
   logic [NUM_REQ-1:0] gnt_ln  = '0;
   logic [NUM_REQ-1:0] pend_m  = '0;
   logic [NUM_REQ-1:0] prev_rv = '0;
   int          exp_rise [NUM_REQ];
   logic [31:0] mul_pipe [MUL_LAT];

   mult_share_arbiter #(.NUM_REQ(NUM_REQ), .MUL_LAT(MUL_LAT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op_a   (req_op_a),
      .req_op_b   (req_op_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .mul_en     (mul_en),
      .mul_op_a   (mul_op_a),
      .mul_op_b   (mul_op_b),
      .mul_result (mul_result),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // External multiplier: registered, unreset, low 32 bits of the product.
   always @(posedge clk) begin
      if (mul_en) mul_pipe[0] <= mul_op_a * mul_op_b;
      for (int s = 1; s < MUL_LAT; s++) mul_pipe[s] <= mul_pipe[s-1];
   end
   assign mul_result = mul_pipe[MUL_LAT-1];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e);
      op_a_q[i].push_back(a);
      op_b_q[i].push_back(b);
      exp_q[i].push_back(e);
   endtask

   task automatic clear_queues();
      for (int i = 0; i < NUM_REQ; i++) begin
         op_a_q[i].delete();
         op_b_q[i].delete();
         exp_q[i].delete();
      end
   endtask

   function automatic bit idle();
      bit r;
      r = (pend_m == '0);
      for (int i = 0; i < NUM_REQ; i++)
         if (op_a_q[i].size() != 0 || exp_q[i].size() != 0) r = 1'b0;
      return r;
   endfunction

   function automatic int count_grants(input int id);
      int n = 0;
      foreach (grant_log[k]) if (grant_log[k] == id) n++;
      return n;
   endfunction

   // Requester model: holds the head operand pair until it is seen granted.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_ln[i] && op_a_q[i].size() > 0) begin
            void'(op_a_q[i].pop_front());
            void'(op_b_q[i].pop_front());
         end
         if (op_a_q[i].size() > 0) begin
            req_valid[i]         = 1'b1;
            req_op_a[32*i +: 32] = op_a_q[i][0];
            req_op_b[32*i +: 32] = op_b_q[i][0];
         end else begin
            req_valid[i]         = 1'b0;
            req_op_a[32*i +: 32] = '0;
            req_op_b[32*i +: 32] = '0;
         end
      end
   end

   // Monitor: grant legality, busy, response timing and scoreboard comparison.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         pend_m  = '0;
         prev_rv = '0;
         gnt_ln  = '0;
         for (int i = 0; i < NUM_REQ; i++) exp_rise[i] = -1;
      end else begin
         check("busy", 32'(busy), 32'(|pend_m));
         check("grant_count", 32'($countones(req_ready)), 32'(|(req_valid & ~pend_m)));
         check("mul_en", 32'(mul_en), 32'(|(req_valid & ~pend_m)));
         if (req_ready != '0) begin
            for (int g = 0; g < NUM_REQ; g++) begin
               if (req_ready[g]) begin
                  check("grant_eligible", 32'(req_valid[g] & ~pend_m[g]), 32'd1);
                  check("mul_op_a", mul_op_a, req_op_a[32*g +: 32]);
                  check("mul_op_b", mul_op_b, req_op_b[32*g +: 32]);
                  grant_log.push_back(g);
                  grant_cyc.push_back(cyc);
                  pend_m[g]   = 1'b1;
                  exp_rise[g] = cyc + MUL_LAT + 1;
               end
            end
         end else begin
            check("idle_ops", mul_op_a | mul_op_b, 32'd0);
         end
         gnt_ln = req_valid & req_ready;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (rsp_valid[i] && !prev_rv[i]) begin
               check($sformatf("rsp_valid_rise_cycle%0d", i), 32'(cyc), 32'(exp_rise[i]));
               exp_rise[i] = -1;
            end
            if (rsp_valid[i] && rsp_ready[i]) begin
               if (exp_q[i].size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_rsp%0d: got 0x%08h, expected no response (cycle %0d)",
                           i, rsp_result[32*i +: 32], cyc);
               end else begin
                  check($sformatf("rsp_result%0d", i), rsp_result[32*i +: 32], exp_q[i].pop_front());
               end
               pend_m[i] = 1'b0;
            end
         end
         prev_rv = rsp_valid;
      end
   end

   task automatic wait_grants(input int n, input string name);
      int k = 0;
      while (grant_log.size() < n && k < 50) begin
         @(negedge clk); #1;
         k++;
      end
      check(name, 32'(grant_log.size() >= n), 32'd1);
   endtask

   task automatic drain(input string name);
      int k = 0;
      while (!idle() && k < 200) begin
         @(negedge clk); #1;
         k++;
      end
      check(name, 32'(idle()), 32'd1);
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      rst_n = 1'b0;
      clear_queues();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      grant_log.delete();
      grant_cyc.delete();
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_op_a  = '0;
      req_op_b  = '0;
      rsp_ready = '1;
      repeat (2) @(negedge clk);
      #1;
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_mul_en", 32'(mul_en), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rsp_result", 32'(|rsp_result), 32'd0);
      @(posedge clk); #2 rst_n = 1'b1;

      // T1 single operation
      issue(0, 32'd3, 32'd5, 32'd15);
      wait_grants(1, "t1_grant_seen");
      check("t1_grant_id", 32'(grant_log[0]), 32'd0);
      drain("t1_drain");

      // T2 all four requesters at once after reset
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) issue(i, 32'hFFFF_FFFE, 32'd7, 32'hFFFF_FFF2);
      wait_grants(4, "t2_grants_seen");
      for (int k = 0; k < 4; k++) begin
         check("t2_grant_order", 32'(grant_log[k]), 32'(k));
         check("t2_grant_cycle", 32'(grant_cyc[k] - grant_cyc[0]), 32'(k));
      end
      drain("t2_drain");
      @(negedge clk); #1;
      check("t2_busy_idle", 32'(busy), 32'd0);

      // T3 backpressure on requester 1
      @(posedge clk); #2;
      rsp_ready[1] = 1'b0;
      grant_log.delete();
      issue(1, 32'd11, 32'd3, 32'd33);
      issue(1, 32'd6, 32'd7, 32'd42);
      issue(0, 32'd1, 32'd100, 32'd100);
      issue(0, 32'd2, 32'd100, 32'd200);
      issue(0, 32'd3, 32'd100, 32'd300);
      issue(2, 32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFF4);
      issue(2, 32'd10, 32'd10, 32'd100);
      issue(2, 32'd0, 32'd123, 32'd0);
      issue(3, 32'd9, 32'd9, 32'd81);
      issue(3, 32'd1000, 32'd1000, 32'h000F_4240);
      issue(3, 32'h0001_0000, 32'h0000_0100, 32'h0100_0000);
      begin
         int k = 0;
         while (k < 80 && (exp_q[0].size() + exp_q[2].size() + exp_q[3].size() != 0)) begin
            @(negedge clk); #1;
            k++;
         end
      end
      @(negedge clk); #1;
      check("t3_others_done", 32'(exp_q[0].size() + exp_q[2].size() + exp_q[3].size()), 32'd0);
      check("t3_req1_single_grant", 32'(count_grants(1)), 32'd1);
      check("t3_req0_grants", 32'(count_grants(0)), 32'd3);
      check("t3_rsp1_held", 32'(rsp_valid[1]), 32'd1);
      check("t3_req1_still_waiting", 32'(req_valid[1]), 32'd1);
      @(posedge clk); #2 rsp_ready[1] = 1'b1;
      drain("t3_drain");
      check("t3_req1_regranted", 32'(count_grants(1)), 32'd2);

      // T4 wrap-around arithmetic
      issue(0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
      issue(1, 32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE);
      issue(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
      issue(3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      issue(3, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780);
      drain("t4_drain");

      // T5 reset while an operation is in flight
      do_reset();
      issue(2, 32'd5, 32'd5, 32'd25);
      wait_grants(1, "t5_grant_seen");
      check("t5_grant_id", 32'(grant_log[0]), 32'd2);
      @(posedge clk); #2;
      rst_n = 1'b0;
      clear_queues();
      @(negedge clk); #1;
      check("t5_rsp_valid_in_reset", 32'(rsp_valid), 32'd0);
      check("t5_busy_in_reset", 32'(busy), 32'd0);
      @(posedge clk); #2 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("t5_rsp_valid_after", 32'(rsp_valid), 32'd0);
      check("t5_busy_after", 32'(busy), 32'd0);
      grant_log.delete();
      issue(3, 32'd4, 32'd4, 32'd16);
      issue(0, 32'd8, 32'd8, 32'd64);
      wait_grants(2, "t5_post_grants_seen");
      check("t5_first_after_reset", 32'(grant_log[0]), 32'd0);
      check("t5_second_after_reset", 32'(grant_log[1]), 32'd3);
      drain("t5_drain");

      // T6 fairness between requesters 0 and 2
      grant_log.delete();
      issue(0, 32'd2, 32'd3, 32'd6);
      issue(0, 32'd4, 32'd4, 32'd16);
      issue(0, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFB);
      issue(0, 32'd7, 32'd8, 32'd56);
      issue(2, 32'd1, 32'd1, 32'd1);
      issue(2, 32'd2, 32'd2, 32'd4);
      issue(2, 32'd3, 32'd3, 32'd9);
      issue(2, 32'd100, 32'd3, 32'h0000_012C);
      drain("t6_drain");
      check("t6_grant_total", 32'(grant_log.size()), 32'd8);
      for (int k = 0; k < 8 && k < grant_log.size(); k++)
         check("t6_alternate", 32'(grant_log[k]), (k % 2 == 0) ? 32'd0 : 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish by %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
